// File: rtl/add_step2_pipe.sv
// Step-2 of the FPU adder: sign-magnitude add/subtract of two aligned fractions,
// registered behind a valid/ready handshake with a 2-entry skid buffer.
module add_step2_pipe #(
  parameter int unsigned FRAC_W = 26,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sub,
  input  logic [FRAC_W-1:0] in_frac1,
  input  logic              in_sign1,
  input  logic [FRAC_W-1:0] in_frac2,
  input  logic              in_sign2,
  input  logic [EXP_W-1:0]  in_exp_max,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [FRAC_W-1:0] out_sum,
  output logic              out_carry,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    logic              sign;
    logic              carry;
    logic [FRAC_W-1:0] sum;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic [TAG_W-1:0]  tag;
  } res_t;

  res_t res_new;
  res_t or_q, or_d, sk_q, sk_d;
  logic or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
  logic s2;
  logic accept, consume;

  // Sign-magnitude add/subtract of the incoming operand set
  always_comb begin
    res_new = '0;
    s2      = in_sign2 ^ in_sub;
    if (in_sign1 == s2) begin
      {res_new.carry, res_new.sum} = {1'b0, in_frac1} + {1'b0, in_frac2};
      res_new.sign = in_sign1;
    end else if (in_frac1 >= in_frac2) begin
      res_new.sum  = in_frac1 - in_frac2;
      res_new.sign = in_sign1;
    end else begin
      res_new.sum  = in_frac2 - in_frac1;
      res_new.sign = s2;
    end
    res_new.zero = (res_new.sum == '0) && !res_new.carry;
    res_new.exp  = res_new.zero ? '0 : in_exp_max;
    // Only -0 + -0 keeps a negative zero
    if (res_new.zero) res_new.sign = in_sign1 & s2;
    res_new.tag = in_tag;
  end

  // in_ready comes straight from a flop so it never depends on out_ready
  assign in_ready  = !sk_valid_q;
  assign out_valid = or_valid_q;
  assign accept    = in_valid && in_ready;
  assign consume   = or_valid_q && out_ready;

  // Next-state for the EMPTY / ONE / TWO occupancy encoded by the valid bits
  always_comb begin
    or_d       = or_q;
    sk_d       = sk_q;
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;
    if (!or_valid_q) begin
      if (accept) begin
        or_d       = res_new;
        or_valid_d = 1'b1;
      end
    end else if (!sk_valid_q) begin
      if (accept && consume) begin
        or_d = res_new;
      end else if (accept) begin
        sk_d       = res_new;
        sk_valid_d = 1'b1;
      end else if (consume) begin
        or_valid_d = 1'b0;
      end
    end else if (consume) begin
      or_d       = sk_q;
      sk_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that also clears the result data
  always_ff @(posedge clk) begin
    if (rst) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
    end
  end

  assign out_sign  = or_q.sign;
  assign out_sum   = or_q.sum;
  assign out_carry = or_q.carry;
  assign out_exp   = or_q.exp;
  assign out_zero  = or_q.zero;
  assign out_tag   = or_q.tag;

endmodule

// File: tb/tb_add_step2_pipe.sv
// Bench for add_step2_pipe: signed-integer reference model plus FIFO scoreboard,
// and directed vectors with literal expectations.
module tb_add_step2_pipe;

  localparam int FW = 26;
  localparam int EW = 8;
  localparam int TW = 4;
  localparam int RW = 1 + 1 + FW + EW + 1 + TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [FW-1:0] in_frac1 = '0;
  logic          in_sign1 = 1'b0;
  logic [FW-1:0] in_frac2 = '0;
  logic          in_sign2 = 1'b0;
  logic [EW-1:0] in_exp_max = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sign;
  logic [FW-1:0] out_sum;
  logic          out_carry;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] prev_out;
  logic          prev_stall = 1'b0;

  add_step2_pipe #(.FRAC_W(FW), .EXP_W(EW), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sub     (in_sub),
    .in_frac1   (in_frac1),
    .in_sign1   (in_sign1),
    .in_frac2   (in_frac2),
    .in_sign2   (in_sign2),
    .in_exp_max (in_exp_max),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .out_exp    (out_exp),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  wire [RW-1:0] out_vec = {out_sign, out_carry, out_sum, out_exp, out_zero, out_tag};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: treat operands as signed integers and take sign/magnitude of the total
  function automatic logic [RW-1:0] model(input logic sub, input logic [FW-1:0] f1,
                                          input logic s1, input logic [FW-1:0] f2,
                                          input logic s2, input logic [EW-1:0] e,
                                          input logic [TW-1:0] tag);
    longint v1, v2, tot, mag;
    logic   es2, sg, z;
    logic [FW:0] m;
    es2 = s2 ^ sub;
    v1  = s1  ? -longint'(f1) : longint'(f1);
    v2  = es2 ? -longint'(f2) : longint'(f2);
    tot = v1 + v2;
    mag = (tot < 0) ? -tot : tot;
    m   = mag[FW:0];
    z   = (tot == 0);
    sg  = z ? (s1 & es2) : (tot < 0);
    return {sg, m[FW], m[FW-1:0], z ? {EW{1'b0}} : e, z, tag};
  endfunction

  // Compare process: occupancy, FIFO contents and stall stability every cycle
  always @(negedge clk) begin
    chk("out_valid_vs_model", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready_vs_model", 64'(in_ready), 64'(exp_q.size() < 2));
    if (prev_stall) chk("stall_stable", 64'({out_valid, out_vec}), 64'({1'b1, prev_out}));
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("result_vs_model", 64'(out_vec), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sub, in_frac1, in_sign1, in_frac2, in_sign2, in_exp_max,
                              in_tag));
      prev_stall = out_valid && !out_ready;
      prev_out   = out_vec;
    end
  end

  // Present one operand set and hold it until accepted (bounded)
  task automatic send(input logic sub, input logic [FW-1:0] f1, input logic s1,
                      input logic [FW-1:0] f2, input logic s2, input logic [EW-1:0] e,
                      input logic [TW-1:0] tag);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_sub = sub; in_frac1 = f1; in_sign1 = s1;
    in_frac2 = f2; in_sign2 = s2; in_exp_max = e; in_tag = tag;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Single op into an empty pipe; result must appear one cycle later
  task automatic directed(input string nm, input logic sub, input logic [FW-1:0] f1,
                          input logic s1, input logic [FW-1:0] f2, input logic s2,
                          input logic [EW-1:0] e, input logic [TW-1:0] tag,
                          input logic [RW-1:0] req);
    out_ready = 1'b1;
    send(sub, f1, s1, f2, s2, e, tag);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'(1));
    chk(nm, 64'(out_vec), 64'(req));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_outputs", 64'(out_vec), 64'(0));
    @(posedge clk); #1;

    directed("carry", 1'b0, 26'h2000000, 1'b0, 26'h2000000, 1'b0, 8'h80, 4'h1,
             {1'b0, 1'b1, 26'h0, 8'h80, 1'b0, 4'h1});
    directed("cancel", 1'b0, 26'h1234567, 1'b0, 26'h1234567, 1'b1, 8'h7F, 4'h2,
             {1'b0, 1'b0, 26'h0, 8'h00, 1'b1, 4'h2});
    directed("neg_zero", 1'b0, 26'h0, 1'b1, 26'h0, 1'b1, 8'h55, 4'h3,
             {1'b1, 1'b0, 26'h0, 8'h00, 1'b1, 4'h3});
    directed("sub_neg", 1'b1, 26'h10, 1'b0, 26'h30, 1'b0, 8'h40, 4'h4,
             {1'b1, 1'b0, 26'h20, 8'h40, 1'b0, 4'h4});
    directed("sub_pos", 1'b1, 26'h30, 1'b0, 26'h10, 1'b0, 8'h40, 4'h5,
             {1'b0, 1'b0, 26'h20, 8'h40, 1'b0, 4'h5});
    directed("mixed_neg", 1'b0, 26'h5, 1'b1, 26'h3, 1'b0, 8'h11, 4'h6,
             {1'b1, 1'b0, 26'h2, 8'h11, 1'b0, 4'h6});
    @(posedge clk); #1;

    // Backpressure: tags 1,2 fill the pipe, tag 3 waits
    out_ready = 1'b0;
    send(1'b0, 26'h1, 1'b0, 26'h1, 1'b0, 8'h01, 4'h1);
    send(1'b0, 26'h2, 1'b0, 26'h2, 1'b0, 8'h02, 4'h2);
    in_valid = 1'b1; in_frac1 = 26'h3; in_frac2 = 26'h3; in_exp_max = 8'h03; in_tag = 4'h3;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    chk("bp_head_tag", 64'(out_tag), 64'(1));
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(1'b0, 26'h3, 1'b0, 26'h3, 1'b0, 8'h03, 4'h3);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-stream from TWO, with a handshake offered in the reset cycle
    out_ready = 1'b0;
    send(1'b0, 26'h7, 1'b0, 26'h1, 1'b1, 8'h20, 4'h7);
    send(1'b0, 26'h8, 1'b1, 26'h1, 1'b1, 8'h21, 4'h8);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mid_outputs", 64'(out_vec), 64'(0));
    @(posedge clk); #1;
    directed("post_reset", 1'b0, 26'h3FFFFFF, 1'b0, 26'h1, 1'b0, 8'hAA, 4'h9,
             {1'b0, 1'b1, 26'h0, 8'hAA, 1'b0, 4'h9});

    // Throughput: back-to-back random ops, the compare process checks each result
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [FW-1:0] a, b;
      a = FW'($urandom);
      b = (i % 7 == 0) ? a : FW'($urandom);
      send(1'($urandom), a, 1'($urandom), b, 1'($urandom), EW'($urandom), TW'(i));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
